// File: rtl/keccak_pkg.sv
// Shared types, constants and the rate/domain-byte lookup for the Keccak absorb path.
package keccak_pkg;

    localparam int unsigned W    = 64;
    localparam int unsigned MAXR = 21;
    localparam int unsigned N    = 24;
    localparam int unsigned BW   = W * MAXR;
    localparam int unsigned SW   = 1600;

    typedef logic [W-1:0] lane;
    typedef lane  [4:0]   plane;
    typedef plane [4:0]   state;

    typedef enum logic [2:0] {
        CmSha3_224  = 3'd0,
        CmSha3_256  = 3'd1,
        CmSha3_384  = 3'd2,
        CmSha3_512  = 3'd3,
        CmShake128  = 3'd4,
        CmShake256  = 3'd5
    } cmode_e;

    localparam logic [7:0] DsSha3  = 8'h06;
    localparam logic [7:0] DsShake = 8'h1F;

    typedef struct packed {
        logic [4:0] rate;
        logic [7:0] ds;
    } rate_ds_t;

    // Unused encodings fall back to SHA3-256.
    function automatic rate_ds_t rate_ds(input logic [2:0] cm);
        rate_ds_t rd;
        case (cm)
            CmSha3_224: rd = '{rate: 5'd18, ds: DsSha3};
            CmSha3_256: rd = '{rate: 5'd17, ds: DsSha3};
            CmSha3_384: rd = '{rate: 5'd13, ds: DsSha3};
            CmSha3_512: rd = '{rate: 5'd9,  ds: DsSha3};
            CmShake128: rd = '{rate: 5'd21, ds: DsShake};
            CmShake256: rd = '{rate: 5'd17, ds: DsShake};
            default:    rd = '{rate: 5'd17, ds: DsSha3};
        endcase
        return rd;
    endfunction

endpackage

// File: rtl/keccak_absorb_frontend_if.sv
// Host word stream and block handshake between the data source, the frontend and round control.
interface keccak_absorb_frontend_if;
    import keccak_pkg::*;

    logic          start;
    logic [W-1:0]  dt_i;
    logic [2:0]    cmode;
    logic          last_block;
    logic          blk_take;
    logic          valid;
    logic          buff_full;
    logic          first;
    logic          last_o;
    logic [BW-1:0] block_o;

    modport master (
        output start, dt_i, cmode, last_block, blk_take,
        input  valid, buff_full, first, last_o, block_o
    );

    modport slave (
        input  start, dt_i, cmode, last_block, blk_take,
        output valid, buff_full, first, last_o, block_o
    );

endinterface

// File: rtl/keccak_pad_fill.sv
// Word buffer and multi-rate padding FSM: fills one rate block, pads the final one.
module keccak_pad_fill
    import keccak_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    keccak_absorb_frontend_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] FULL = 2'd2;
    localparam logic [1:0] PAD  = 2'd3;

    logic [1:0]    r_state;
    logic [4:0]    r_wcnt;
    logic [4:0]    r_rate;
    logic [7:0]    r_ds;
    logic          r_pend;
    logic          r_full;
    logic          r_first;
    logic          r_last;
    logic [BW-1:0] r_block;

    rate_ds_t      w_rd;
    logic          w_at_end;
    logic [10:0]   w_base;
    logic [10:0]   w_top;
    logic [BW-1:0] w_fill_blk;
    logic [BW-1:0] w_pad_blk;

    assign w_rd     = rate_ds(bus.cmode);
    assign w_at_end = (r_wcnt == r_rate - 5'd1);
    assign w_base   = {r_wcnt, 6'd0};
    assign w_top    = {r_rate, 6'd0} - 11'd1;

    // Lanes above the write pointer are still zero, so DS and the final bit can be placed directly.
    always_comb begin
        w_fill_blk = r_block;
        w_fill_blk[w_base +: W] = bus.dt_i;
        if (bus.last_block && !w_at_end) begin
            w_fill_blk[w_base + 11'd64 +: 8] = r_ds;
            w_fill_blk[w_top] = 1'b1;
        end
    end

    always_comb begin
        w_pad_blk        = '0;
        w_pad_blk[7:0]   = r_ds;
        w_pad_blk[w_top] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= IDLE;
            r_wcnt  <= '0;
            r_rate  <= '0;
            r_ds    <= '0;
            r_pend  <= 1'b0;
            r_full  <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_block <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= FILL;
                        r_wcnt  <= '0;
                        r_block <= '0;
                        r_first <= 1'b1;
                        r_last  <= 1'b0;
                        r_pend  <= 1'b0;
                        r_rate  <= w_rd.rate;
                        r_ds    <= w_rd.ds;
                    end
                end
                FILL: begin
                    r_block <= w_fill_blk;
                    if (w_at_end || bus.last_block) begin
                        r_state <= FULL;
                        r_full  <= 1'b1;
                        r_last  <= bus.last_block && !w_at_end;
                        r_pend  <= bus.last_block && w_at_end;
                    end else begin
                        r_wcnt <= r_wcnt + 5'd1;
                    end
                end
                FULL: begin
                    if (bus.blk_take) begin
                        r_full  <= 1'b0;
                        r_first <= 1'b0;
                        if (r_pend) begin
                            r_state <= PAD;
                            r_pend  <= 1'b0;
                            r_block <= w_pad_blk;
                        end else if (r_last) begin
                            r_state <= IDLE;
                            r_last  <= 1'b0;
                        end else begin
                            r_state <= FILL;
                            r_block <= '0;
                            r_wcnt  <= '0;
                        end
                    end
                end
                default: begin
                    // Pad-only block: present it without requesting any word.
                    r_state <= FULL;
                    r_full  <= 1'b1;
                    r_last  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.valid     = (r_state == FILL);
    assign bus.buff_full = r_full;
    assign bus.first     = r_first;
    assign bus.last_o    = r_last;
    assign bus.block_o   = r_block;

endmodule

// File: rtl/keccak_absorb_frontend.sv
// Keccak input side: block buffer/padding, VSX state XOR and round-array flattening.
module keccak_absorb_frontend
    import keccak_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    keccak_absorb_frontend_if.slave bus,
    input  logic                    en_vsx,
    input  logic [SW-1:0]           state_i,
    input  state                    round_arr_i,
    output logic [SW-1:0]           state_o,
    output logic [SW-1:0]           round_str_o
);

    keccak_pad_fill u_pad_fill (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign state_o[BW-1:0]  = en_vsx ? (state_i[BW-1:0] ^ bus.block_o) : state_i[BW-1:0];
    assign state_o[SW-1:BW] = state_i[SW-1:BW];

    for (genvar y = 0; y < 5; y++) begin : g_y
        for (genvar x = 0; x < 5; x++) begin : g_x
            assign round_str_o[W*(5*y+x) +: W] = round_arr_i[x][y];
        end
    end

endmodule

// File: tb/tb_keccak_absorb_frontend.sv
// Scoreboard bench: a byte-level sponge padding model predicts every block the frontend presents.
module tb_keccak_absorb_frontend;
    import keccak_pkg::*;

    typedef struct {
        logic [1343:0] blk;
        bit            first;
        bit            last;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          en_vsx;
    logic [1599:0] state_i;
    state          round_arr_i;
    logic [1599:0] state_o;
    logic [1599:0] round_str_o;

    int checks;
    int errors;

    exp_t          exp_q[$];
    logic [1343:0] g_cap[$];
    logic [63:0]   g_words[$];

    keccak_absorb_frontend_if bus ();

    keccak_absorb_frontend dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .en_vsx      (en_vsx),
        .state_i     (state_i),
        .round_arr_i (round_arr_i),
        .state_o     (state_o),
        .round_str_o (round_str_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int first_diff(input logic [1343:0] a, input logic [1343:0] b);
        for (int l = 0; l < 21; l++) begin
            if (a[l*64 +: 64] !== b[l*64 +: 64]) return l;
        end
        return -1;
    endfunction

    task automatic model_rate(input logic [2:0] mode, output int rate, output logic [7:0] ds);
        case (mode)
            3'd0:    begin rate = 18; ds = 8'h06; end
            3'd1:    begin rate = 17; ds = 8'h06; end
            3'd2:    begin rate = 13; ds = 8'h06; end
            3'd3:    begin rate = 9;  ds = 8'h06; end
            3'd4:    begin rate = 21; ds = 8'h1F; end
            3'd5:    begin rate = 17; ds = 8'h1F; end
            default: begin rate = 17; ds = 8'h06; end
        endcase
    endtask

    // Message bytes, then DS, zero fill, and 0x80 in the last byte of the final rate block.
    task automatic push_model(input int rate, input logic [7:0] ds, input int n);
        int   nblk;
        int   w;
        exp_t e;
        nblk = n / rate + 1;
        for (int b = 0; b < nblk; b++) begin
            e.blk = '0;
            for (int l = 0; l < rate; l++) begin
                w = b * rate + l;
                if (w < n) e.blk[l*64 +: 64] = g_words[w];
                else if (w == n) e.blk[l*64 +: 8] = ds;
            end
            if (b == nblk - 1) e.blk[rate*64-1] = 1'b1;
            e.first = (b == 0);
            e.last  = (b == nblk - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic fill_words(input int n, input int kind);
        g_words.delete();
        for (int i = 0; i < n; i++) begin
            if (kind == 0)      g_words.push_back(64'h0);
            else if (kind == 1) g_words.push_back({64{1'b1}});
            else                g_words.push_back({$urandom, $urandom});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.start = 1'b0;
        bus.blk_take = 1'b0;
        bus.last_block = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic run_msg(input logic [2:0] mode, input int n, input int take_dly, input bit hold);
        int   rate;
        logic [7:0] ds;
        int   idx, cyc, wait_cnt, dl;
        bit   seen_full, done, pend_lat, cur_last;
        exp_t e;
        model_rate(mode, rate, ds);
        push_model(rate, ds, n);
        g_cap.delete();
        idx = 0; cyc = 0; wait_cnt = 0;
        seen_full = 0; done = 0; pend_lat = 0; cur_last = 0;
        @(negedge clk);
        bus.cmode = mode;
        bus.start = 1'b1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            bus.start      = 1'b0;
            bus.blk_take   = 1'b0;
            bus.cmode      = mode + 3'd1;
            bus.last_block = 1'b1;
            bus.dt_i       = {$urandom, $urandom};
            if (cyc == 1) begin
                checks++;
                if (bus.valid !== 1'b1 || bus.first !== 1'b1 || bus.block_o !== '0) begin
                    errors++;
                    $display("FAIL start_response: valid=%b first=%b block_zero=%b, required 1 1 1",
                             bus.valid, bus.first, bus.block_o === '0);
                end
            end
            if (pend_lat) begin
                pend_lat = 0;
                checks++;
                if (bus.buff_full !== 1'b1) begin
                    errors++;
                    $display("FAIL full_latency: buff_full=%b one cycle after block end, required 1",
                             bus.buff_full);
                end
            end
            if (bus.buff_full === 1'b1) begin
                if (!seen_full) begin
                    seen_full = 1;
                    wait_cnt  = 0;
                    g_cap.push_back(bus.block_o);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_block: block presented, required none");
                        done = 1;
                    end else begin
                        e = exp_q.pop_front();
                        cur_last = e.last;
                        dl = first_diff(bus.block_o, e.blk);
                        if (dl >= 0 || bus.first !== e.first || bus.last_o !== e.last) begin
                            errors++;
                            $display("FAIL block_%0d: lane %0d got %h required %h, first %b/%b last %b/%b",
                                     g_cap.size() - 1, dl, (dl >= 0) ? bus.block_o[dl*64 +: 64] : 64'h0,
                                     (dl >= 0) ? e.blk[dl*64 +: 64] : 64'h0,
                                     bus.first, e.first, bus.last_o, e.last);
                        end
                    end
                    if (hold) done = 1;
                end
                checks++;
                if (bus.valid !== 1'b0) begin
                    errors++;
                    $display("FAIL valid_in_full: valid=%b while buff_full, required 0", bus.valid);
                end
                if (!done) begin
                    if (wait_cnt == take_dly) begin
                        bus.blk_take = 1'b1;
                        bus.start    = 1'b1;
                        seen_full    = 0;
                        if (cur_last) done = 1;
                    end else begin
                        wait_cnt++;
                    end
                end
            end else if (bus.valid === 1'b1) begin
                if (idx < n) begin
                    bus.dt_i       = g_words[idx];
                    bus.last_block = (idx == n - 1);
                    pend_lat       = (idx == n - 1) || (idx % rate == rate - 1);
                    idx++;
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL extra_request: valid=1 after %0d words, required 0", n);
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: mode %0d message not completed within 400 cycles", mode);
        end else if (!hold) begin
            @(negedge clk);
            bus.blk_take = 1'b0;
            bus.start    = 1'b0;
            checks++;
            if (bus.valid !== 1'b0 || bus.buff_full !== 1'b0 || bus.last_o !== 1'b0 ||
                exp_q.size() != 0) begin
                errors++;
                $display("FAIL end_idle: valid=%b buff_full=%b last_o=%b pending=%0d, required 0 0 0 0",
                         bus.valid, bus.buff_full, bus.last_o, exp_q.size());
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        checks++;
        if (bus.valid !== 1'b0 || bus.buff_full !== 1'b0 || bus.first !== 1'b0 ||
            bus.last_o !== 1'b0 || bus.block_o !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b full=%b first=%b last=%b block_zero=%b, required 0 0 0 0 1",
                     bus.valid, bus.buff_full, bus.first, bus.last_o, bus.block_o === '0);
        end
        @(negedge clk);
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid: valid=%b without start, required 0", bus.valid);
        end
    endtask

    task automatic test_shake256_short();
        logic [1343:0] ref_blk;
        fill_words(2, 0);
        run_msg(3'd5, 2, 1, 0);
        ref_blk = '0;
        ref_blk[2*64 +: 64]  = 64'h1F;
        ref_blk[16*64 +: 64] = 64'h8000_0000_0000_0000;
        checks++;
        if (g_cap.size() != 1 || g_cap[0] !== ref_blk) begin
            errors++;
            $display("FAIL shake256_short: %0d blocks, lane2=%h lane16=%h, required 1 block 1f 8000000000000000",
                     g_cap.size(), g_cap[0][2*64 +: 64], g_cap[0][16*64 +: 64]);
        end
    endtask

    task automatic test_multi_block();
        logic [1343:0] ref_blk;
        fill_words(32, 1);
        run_msg(3'd3, 32, 2, 0);
        ref_blk = '0;
        ref_blk[5*64-1:0]   = {320{1'b1}};
        ref_blk[5*64 +: 64] = 64'h06;
        ref_blk[8*64 +: 64] = 64'h8000_0000_0000_0000;
        checks++;
        if (g_cap.size() != 4 || g_cap[3] !== ref_blk) begin
            errors++;
            $display("FAIL multi_block_tail: %0d blocks, lane5=%h lane8=%h, required 4 blocks 6 8000000000000000",
                     g_cap.size(), g_cap[3][5*64 +: 64], g_cap[3][8*64 +: 64]);
        end
    endtask

    task automatic test_exact_fill();
        logic [1343:0] ref_blk;
        fill_words(9, 2);
        run_msg(3'd3, 9, 2, 0);
        ref_blk = '0;
        ref_blk[7:0] = 8'h06;
        ref_blk[9*64-1] = 1'b1;
        checks++;
        if (g_cap.size() != 2 || g_cap[1] !== ref_blk) begin
            errors++;
            $display("FAIL exact_fill_pad: %0d blocks, lane0=%h lane8=%h, required 2 blocks 6 8000000000000000",
                     g_cap.size(), g_cap[1][63:0], g_cap[1][8*64 +: 64]);
        end
    endtask

    task automatic test_sha3_256_boundary();
        fill_words(16, 2);
        run_msg(3'd1, 16, 0, 0);
        checks++;
        if (g_cap.size() != 1 || g_cap[0][16*64 +: 64] !== 64'h8000_0000_0000_0006) begin
            errors++;
            $display("FAIL sha3_256_merged_pad: lane16=%h, required 8000000000000006",
                     g_cap[0][16*64 +: 64]);
        end
    endtask

    task automatic test_modes();
        logic [2:0] modes[4];
        int n;
        modes[0] = 3'd0; modes[1] = 3'd2; modes[2] = 3'd4; modes[3] = 3'd6;
        for (int m = 0; m < 4; m++) begin
            n = 1 + $urandom_range(0, 45);
            fill_words(n, 2);
            run_msg(modes[m], n, $urandom_range(0, 3), 0);
        end
    endtask

    task automatic test_vsx();
        logic [1599:0] ref_st;
        fill_words(21, 1);
        run_msg(3'd4, 21, 0, 1);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.buff_full !== 1'b1 || bus.valid !== 1'b0 || bus.block_o !== {1344{1'b1}}) begin
            errors++;
            $display("FAIL full_hold: buff_full=%b valid=%b block_ones=%b, required 1 0 1",
                     bus.buff_full, bus.valid, bus.block_o === {1344{1'b1}});
        end
        for (int i = 0; i < 50; i++) state_i[i*32 +: 32] = $urandom;
        en_vsx = 1'b1;
        #1;
        ref_st = {state_i[1599:1344], ~state_i[1343:0]};
        checks++;
        if (state_o !== ref_st) begin
            errors++;
            $display("FAIL vsx_on: state_o[63:0]=%h [1599:1536]=%h, required %h %h",
                     state_o[63:0], state_o[1599:1536], ref_st[63:0], ref_st[1599:1536]);
        end
        en_vsx = 1'b0;
        #1;
        checks++;
        if (state_o !== state_i) begin
            errors++;
            $display("FAIL vsx_off: state_o[63:0]=%h, required %h", state_o[63:0], state_i[63:0]);
        end
        do_reset();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_fill();
        @(negedge clk);
        bus.cmode = 3'd4;
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.start      = 1'b0;
            bus.dt_i       = {$urandom, $urandom} | 64'h1;
            bus.last_block = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        checks++;
        if (bus.valid !== 1'b0 || bus.buff_full !== 1'b0 || bus.block_o !== '0 || bus.first !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_fill: valid=%b full=%b first=%b block_zero=%b, required 0 0 0 1",
                     bus.valid, bus.buff_full, bus.first, bus.block_o === '0);
        end
        fill_words(20, 2);
        run_msg(3'd0, 20, 1, 0);
    endtask

    task automatic test_round_str();
        int bad;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                round_arr_i[x][y] = {$urandom, $urandom};
        round_arr_i[1][2] = 64'hA5;
        #1;
        checks++;
        if (round_str_o[64*11 +: 64] !== 64'hA5) begin
            errors++;
            $display("FAIL round_str_a5: lane11=%h, required a5", round_str_o[64*11 +: 64]);
        end
        bad = 0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                if (round_str_o[64*(5*y+x) +: 64] !== round_arr_i[x][y]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL round_str_map: %0d misplaced lanes, required 0", bad);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b1;
        en_vsx = 1'b0;
        state_i = '0;
        round_arr_i = '0;
        bus.start = 1'b0;
        bus.dt_i = '0;
        bus.cmode = '0;
        bus.last_block = 1'b0;
        bus.blk_take = 1'b0;
        test_reset();
        test_shake256_short();
        test_multi_block();
        test_exact_fill();
        test_sha3_256_boundary();
        test_modes();
        test_vsx();
        test_reset_mid_fill();
        test_round_str();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
